// File: rtl/template_match_ctrl.sv
// template_match_ctrl
//   Scans NUM_DIGITS templates of PIX_NUM pixels against one captured image and
//   reports the digit with the minimum sum of absolute differences (SAD).
//   Template ROM is combinational; the image buffer has a one-cycle read latency,
//   so the template pixel is registered once to line up with the image pixel.
//   Optional feature macro: TM_EARLY_ABORT_EN (abandon a digit once its partial
//   SAD can no longer beat the best so far; same result, shorter scan).
//
//   Handshake: start is a level sampled only in IDLE. busy is high in every
//   non-IDLE state, done is a one-cycle pulse in FIN, and match_digit/match_score
//   are valid from the done cycle and held until the next done.
module template_match_ctrl #(
  parameter int PIX_NUM    = 784,
  parameter int NUM_DIGITS = 10,
  parameter int PIX_W      = 8,
  parameter int SCORE_W    = 18
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [3:0]         tpl_digit,
  output logic [9:0]         tpl_index,
  input  logic [PIX_W-1:0]   tpl_pixel,
  output logic [9:0]         img_addr,
  input  logic [PIX_W-1:0]   img_pixel,
  output logic [3:0]         match_digit,
  output logic [SCORE_W-1:0] match_score,
  output logic [2:0]         o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DRAIN = 3'd2,
    S_CMP   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_digit;
  logic [9:0]           r_index;
  logic [PIX_W-1:0]     r_tpl_q;
  logic                 r_pipe_vld;
  logic [SCORE_W-1:0]   r_acc;
  logic [SCORE_W-1:0]   r_best_score;
  logic [3:0]           r_best_digit;
  logic [3:0]           r_match_digit;
  logic [SCORE_W-1:0]   r_match_score;

  logic                 w_last_idx;
  logic                 w_last_digit;
  logic                 w_abort;
  logic [PIX_W-1:0]     w_diff;
  logic                 w_take;
  logic [SCORE_W-1:0]   w_best_score_nx;
  logic [3:0]           w_best_digit_nx;

  assign w_last_idx   = (r_index == 10'(PIX_NUM - 1));
  assign w_last_digit = (r_digit == 4'(NUM_DIGITS - 1));

`ifdef TM_EARLY_ABORT_EN
  // A digit whose partial SAD already reaches the best cannot win (ties keep
  // the lower digit), so stop scanning it. Digit 0 always runs to completion.
  assign w_abort = ((r_state == S_ADDR) || (r_state == S_DRAIN)) &&
                   (r_digit != 4'd0) && (r_acc >= r_best_score);
`else
  assign w_abort = 1'b0;
`endif

  // Absolute difference and best-candidate selection for the CMP step
  always_comb begin
    w_diff          = (img_pixel >= r_tpl_q) ? (img_pixel - r_tpl_q) : (r_tpl_q - img_pixel);
    w_take          = (r_acc < r_best_score);
    w_best_score_nx = w_take ? r_acc : r_best_score;
    w_best_digit_nx = w_take ? r_digit : r_best_digit;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_ADDR;
      S_ADDR: begin
        if (w_abort)         w_next = S_CMP;
        else if (w_last_idx) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_CMP;
      S_CMP:   w_next = w_last_digit ? S_FIN : S_ADDR;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Template pixel alignment stage; an aborted address is never accumulated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tpl_q    <= '0;
      r_pipe_vld <= 1'b0;
    end else begin
      r_tpl_q    <= tpl_pixel;
      r_pipe_vld <= (r_state == S_ADDR) && !w_abort;
    end
  end

  // Address sequencing, SAD accumulation and best/result tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit       <= '0;
      r_index       <= '0;
      r_acc         <= '0;
      r_best_score  <= '0;
      r_best_digit  <= '0;
      r_match_digit <= '0;
      r_match_score <= '1;
    end else begin
      if (r_pipe_vld && !w_abort)
        r_acc <= r_acc + SCORE_W'(w_diff);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_digit      <= '0;
            r_index      <= '0;
            r_acc        <= '0;
            r_best_score <= '1;
            r_best_digit <= '0;
          end
        end
        S_ADDR: begin
          if (!w_abort && !w_last_idx)
            r_index <= r_index + 10'd1;
        end
        S_CMP: begin
          r_acc        <= '0;
          r_best_score <= w_best_score_nx;
          r_best_digit <= w_best_digit_nx;
          if (w_last_digit) begin
            r_match_digit <= w_best_digit_nx;
            r_match_score <= w_best_score_nx;
          end else begin
            r_digit <= r_digit + 4'd1;
            r_index <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FIN);
  assign tpl_digit   = r_digit;
  assign tpl_index   = r_index;
  assign img_addr    = r_index;
  assign match_digit = r_match_digit;
  assign match_score = r_match_score;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_template_match_ctrl.sv
// Directed bench for template_match_ctrl: behavioural image RAM (one-cycle read)
// and template ROM, hand-computed SAD results, latency and start/reset handling.
module tb_template_match_ctrl;

  localparam int SCORE_W = 18;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic [3:0]         tpl_digit;
  logic [9:0]         tpl_index;
  logic [7:0]         tpl_pixel;
  logic [9:0]         img_addr;
  logic [7:0]         img_pixel;
  logic [3:0]         match_digit;
  logic [SCORE_W-1:0] match_score;
  logic [2:0]         dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  img_mem [0:783];
  logic        rom_mode;
  logic [3:0]  prev_digit;
  logic [31:0] prev_score;

  template_match_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .tpl_digit   (tpl_digit),
    .tpl_index   (tpl_index),
    .tpl_pixel   (tpl_pixel),
    .img_addr    (img_addr),
    .img_pixel   (img_pixel),
    .match_digit (match_digit),
    .match_score (match_score),
    .o_dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Template ROM: mode 0 -> digit0 all FF, others 00; mode 1 -> digit d all d*16
  assign tpl_pixel = rom_mode ? 8'(tpl_digit * 16) : ((tpl_digit == 4'd0) ? 8'hFF : 8'h00);

  // Image buffer with one-cycle read latency
  always @(posedge clk) img_pixel <= img_mem[img_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_img(input logic [7:0] v);
    for (int i = 0; i < 784; i++) img_mem[i] = v;
  endtask

  // One complete scan: pulse start, follow it to done, check latency/result
  task automatic run_scan(input string tag, input logic [3:0] exp_digit,
                          input logic [31:0] exp_score, input bit inject);
    int done_cyc;
    int busy_low;
    int extra;
    done_cyc = 0;
    busy_low = 0;
    extra    = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;   // start-accept edge; now in cycle 1
    start = 1'b0;
    for (int c = 1; c <= 9000; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (inject && c == 100) start = 1'b1;
      if (inject && c == 101) start = 1'b0;
      if (c == 10) begin
        chk({tag, "_held_digit"}, 32'(match_digit), 32'(prev_digit));
        chk({tag, "_held_score"}, 32'(match_score), prev_score);
      end
      if (!busy) busy_low++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
`ifdef TM_EARLY_ABORT_EN
    chk({tag, "_early"}, 32'((done_cyc > 0) && (done_cyc < 7861)), 32'd1);
`else
    chk({tag, "_latency"}, 32'(done_cyc), 32'd7861);
`endif
    chk({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
    chk({tag, "_digit"}, 32'(match_digit), 32'(exp_digit));
    chk({tag, "_score"}, 32'(match_score), exp_score);
    repeat (20) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk({tag, "_single_done"}, 32'(extra), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_hold_digit"}, 32'(match_digit), 32'(exp_digit));
    prev_digit = exp_digit;
    prev_score = exp_score;
  endtask

  initial begin
    int dn;
    rst_n    = 1'b0;
    start    = 1'b0;
    rom_mode = 1'b0;
    fill_img(8'h00);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_digit", 32'(tpl_digit), 32'd0);
    chk("rst_index", 32'(tpl_index), 32'd0);
    chk("rst_addr",  32'(img_addr), 32'd0);
    chk("rst_mdig",  32'(match_digit), 32'd0);
    chk("rst_mscr",  32'(match_score), 32'h3FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    prev_digit = 4'd0;
    prev_score = 32'h3FFFF;

    // Image 00: digit0 SAD 199920, digits 1-9 SAD 0, tie keeps digit 1
    fill_img(8'h00);
    run_scan("t1_zero", 4'd1, 32'd0, 1'b0);

    // Image FF: digit0 SAD 0
    fill_img(8'hFF);
    run_scan("t2_ff", 4'd0, 32'd0, 1'b0);

    // Image 80: digit0 784*127=99568, digits 1-9 784*128=100352
    fill_img(8'h80);
    run_scan("t3_mid", 4'd0, 32'd99568, 1'b0);

    // Graded ROM (digit d = d*16), image 0x70 with two off pixels:
    // digit7 SAD = |0x75-0x70| + |0x6E-0x70| = 5 + 2 = 7 (last index included)
    rom_mode = 1'b1;
    fill_img(8'h70);
    img_mem[5]   = 8'h75;
    img_mem[783] = 8'h6E;
    run_scan("t_graded", 4'd7, 32'd7, 1'b0);

    // Repeated start mid-scan is ignored
    rom_mode = 1'b0;
    fill_img(8'h80);
    run_scan("t4_restart", 4'd0, 32'd99568, 1'b1);

    // Reset at cycle 3000 of a scan aborts it
    fill_img(8'hFF);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2999) @(posedge clk);
    #1;
    chk("t5_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_mscr", 32'(match_score), 32'h3FFFF);
    chk("t5_rst_mdig", 32'(match_digit), 32'd0);
    chk("t5_rst_index", 32'(tpl_index), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("t5_no_done", 32'(dn), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    prev_digit = 4'd0;
    prev_score = 32'h3FFFF;
    run_scan("t5_after", 4'd0, 32'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
